// File: rtl/pc_gen_pkg.sv
// Shared front-end types for the fetch PC generator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pc_gen_pkg;

    typedef logic [31:0] virt_t;

    // Branch prediction result as produced by the BPU for the branch in decode.
    typedef struct packed {
        logic       valid;
        logic [3:0] br_op;
        logic       br_taken;
        virt_t      target;
    } predict_result_t;

    // Sources that force a full front-end redirect.
    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
    } pipeline_flush_t;

    // SEQ: walking sequentially.
    // WAIT_DS: taken redirect latched, delay slot not yet accepted.
    // CORR: correction target loaded, waiting for the I-cache to take it.
    typedef enum logic [1:0] {
        SEQ     = 2'd0,
        WAIT_DS = 2'd1,
        CORR    = 2'd2
    } pc_state_e;

    function automatic virt_t seq_next(input virt_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// I-cache instruction request channel (req / addr_ok handshake).
// Latency: combinational; the request is taken in any cycle with inst_req & inst_addr_ok.
// Backpressure: the cache holds off by leaving inst_addr_ok low; inst_addr stays stable.
//   inst_req     : request valid (fetch side)
//   inst_addr    : word-aligned fetch address (fetch side)
//   inst_addr_ok : cache accepted inst_addr this cycle (cache side)
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic  inst_req;
    virt_t inst_addr;
    logic  inst_addr_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok
    );

endinterface

// File: rtl/pc_gen.sv
// Pre-IF next-PC generator: owns the fetch PC, redirects on flush / correction / taken prediction.
// Latency: inst_addr is the PC register; redirects take effect on the next cycle, fs_cancel is same-cycle.
// Backpressure: fs_stall drops inst_req; inst_addr_ok low holds the PC; redirects still update it.
//   clk, reset                        : clock, synchronous active-high reset
//   flush_valid / flush_target        : exception, ERET or TLB refetch redirect
//   bpu_pred_valid / bpu_br_taken /
//   bpu_target / ds_pc                : prediction for the branch in decode
//   bpu_is_correction /
//   bpu_correct_target                : BPU misprediction correction request
//   correct_finish                    : pulse when the correction address is accepted
//   fs_cancel                         : pulse discarding fetches younger than the redirect point
//   fs_stall                          : IF buffer full
//   ic                                : I-cache request channel
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter virt_t RESET_PC = 32'hbfc0_0000,
    parameter int    Q_ACCEPT = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush_valid,
    input  virt_t flush_target,
    input  logic  bpu_pred_valid,
    input  logic  bpu_br_taken,
    input  virt_t bpu_target,
    input  virt_t ds_pc,
    input  logic  bpu_is_correction,
    input  virt_t bpu_correct_target,
    output logic  correct_finish,
    output logic  fs_cancel,
    input  logic  fs_stall,
    pc_gen_if.master ic
);

    // Only a single latched redirect slot (pend_target) exists.
    if (Q_ACCEPT != 1) begin : g_bad_q_accept
        $error("pc_gen supports only Q_ACCEPT == 1");
    end

    virt_t     pc_q, pc_d;
    virt_t     last_acc_q, last_acc_d;
    virt_t     pend_q, pend_d;
    virt_t     ds_addr;
    pc_state_e state_q, state_d;
    logic      accept;
    logic      pred_taken;

    assign ic.inst_req  = ~fs_stall & ~reset;
    assign ic.inst_addr = pc_q;
    assign accept       = ic.inst_req & ic.inst_addr_ok;

    // last_acc_d is the newest address the cache holds, including this cycle's accept.
    assign last_acc_d   = accept ? pc_q : last_acc_q;
    assign ds_addr      = seq_next(ds_pc);
    assign pred_taken   = bpu_pred_valid & bpu_br_taken;

    always_comb begin
        pc_d           = pc_q;
        state_d        = state_q;
        pend_d         = pend_q;
        fs_cancel      = 1'b0;
        correct_finish = 1'b0;

        if (!reset) begin
            if (flush_valid) begin
                // The BPU resets itself on flush, so no correct_finish here.
                // Leaving WAIT_DS/CORR is what drops any pending redirect.
                pc_d      = flush_target;
                state_d   = SEQ;
                fs_cancel = 1'b1;
            end else if (bpu_is_correction && state_q != CORR) begin
                pc_d      = bpu_correct_target;
                state_d   = CORR;
                fs_cancel = 1'b1;
            end else if (pred_taken && state_q == SEQ) begin
                if (pc_q == ds_addr && last_acc_d != ds_addr) begin
                    // Delay slot is the current PC and not yet taken: hold it, redirect afterwards.
                    state_d = WAIT_DS;
                    pend_d  = bpu_target;
                end else begin
                    // Delay slot already issued (or behind us): redirect now. Anything
                    // accepted after the delay slot is on the wrong path.
                    pc_d      = bpu_target;
                    fs_cancel = (last_acc_d != ds_addr);
                end
            end else if (accept) begin
                unique case (state_q)
                    SEQ: begin
                        pc_d = seq_next(pc_q);
                    end
                    WAIT_DS: begin
                        pc_d    = pend_q;
                        state_d = SEQ;
                    end
                    CORR: begin
                        pc_d           = seq_next(pc_q);
                        state_d        = SEQ;
                        correct_finish = 1'b1;
                    end
                    default: begin
                        state_d = SEQ;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            last_acc_q <= RESET_PC - 32'd4;
            pend_q     <= '0;
            state_q    <= SEQ;
        end else begin
            pc_q       <= pc_d;
            last_acc_q <= last_acc_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed fetch-redirect scenarios plus a randomized run
// against a behavioural reference model of the fetch stream.
// Outputs are sampled mid-cycle, inputs driven shortly after the rising edge.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic  clk = 1'b0;
    logic  reset;
    logic  flush_valid;
    logic [31:0] flush_target;
    logic  bpu_pred_valid;
    logic  bpu_br_taken;
    logic [31:0] bpu_target;
    logic [31:0] ds_pc;
    logic  bpu_is_correction;
    logic [31:0] bpu_correct_target;
    logic  correct_finish;
    logic  fs_cancel;
    logic  fs_stall;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen_if ic ();

    pc_gen #(.RESET_PC(RST_PC), .Q_ACCEPT(1)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush_valid        (flush_valid),
        .flush_target       (flush_target),
        .bpu_pred_valid     (bpu_pred_valid),
        .bpu_br_taken       (bpu_br_taken),
        .bpu_target         (bpu_target),
        .ds_pc              (ds_pc),
        .bpu_is_correction  (bpu_is_correction),
        .bpu_correct_target (bpu_correct_target),
        .correct_finish     (correct_finish),
        .fs_cancel          (fs_cancel),
        .fs_stall           (fs_stall),
        .ic                 (ic)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush_valid = 1'b0; flush_target = '0;
        bpu_pred_valid = 1'b0; bpu_br_taken = 1'b0; bpu_target = '0; ds_pc = '0;
        bpu_is_correction = 1'b0; bpu_correct_target = '0;
        fs_stall = 1'b0; ic.inst_addr_ok = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    // ---------------- reference model: the fetch stream as a cursor plus history ----------------
    localparam int M_SEQ = 0, M_WAIT = 1, M_CORR = 2;
    logic [31:0] m_pc, m_newest, m_pend;
    int          m_mode;
    logic        e_req, e_cancel, e_finish;
    logic [31:0] e_addr;
    logic [31:0] n_pc, n_newest, n_pend;
    int          n_mode;

    task automatic model_reset();
        m_pc = RST_PC; m_newest = RST_PC - 32'd4; m_pend = '0; m_mode = M_SEQ;
    endtask

    task automatic model_eval();
        logic        taken_now;
        logic [31:0] slot, newest;
        e_req    = !reset && !fs_stall;
        e_addr   = m_pc;
        taken_now = e_req && ic.inst_addr_ok;
        newest   = taken_now ? m_pc : m_newest;
        slot     = ds_pc + 32'd4;
        e_cancel = 1'b0;
        e_finish = 1'b0;
        n_pc = m_pc; n_newest = newest; n_pend = m_pend; n_mode = m_mode;
        if (reset) begin
            n_pc = RST_PC; n_newest = RST_PC - 32'd4; n_mode = M_SEQ;
        end else if (flush_valid) begin
            n_pc = flush_target; n_mode = M_SEQ; e_cancel = 1'b1;
        end else if (bpu_is_correction && m_mode != M_CORR) begin
            n_pc = bpu_correct_target; n_mode = M_CORR; e_cancel = 1'b1;
        end else if (bpu_pred_valid && bpu_br_taken && m_mode == M_SEQ) begin
            if (m_pc == slot && newest != slot) begin
                n_mode = M_WAIT; n_pend = bpu_target;
            end else begin
                n_pc = bpu_target;
                e_cancel = (newest != slot);
            end
        end else if (taken_now) begin
            if (m_mode == M_WAIT) begin
                n_pc = m_pend; n_mode = M_SEQ;
            end else begin
                if (m_mode == M_CORR) e_finish = 1'b1;
                n_pc = m_pc + 32'd4; n_mode = M_SEQ;
            end
        end
    endtask

    task automatic model_commit();
        m_pc = n_pc; m_newest = n_newest; m_pend = n_pend; m_mode = n_mode;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        adv();
        settle();
        n_cmp++; if (ic.inst_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", ic.inst_req); end
        n_cmp++; if (fs_cancel !== 1'b0) begin n_bad++; $display("FAIL reset_cancel: got %b want 0", fs_cancel); end
        n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", correct_finish); end
        reset = 1'b0;
        settle();
        n_cmp++; if (ic.inst_req !== 1'b1) begin n_bad++; $display("FAIL post_reset_req: got %b want 1", ic.inst_req); end
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0000) begin n_bad++; $display("FAIL addr0: got %h want bfc00000", ic.inst_addr); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0004) begin n_bad++; $display("FAIL addr1: got %h want bfc00004", ic.inst_addr); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0008) begin n_bad++; $display("FAIL addr2: got %h want bfc00008", ic.inst_addr); end
        n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL seq_finish: got %b want 0", correct_finish); end
    endtask

    task automatic test_taken_after_ds();
        do_reset();
        repeat (6) adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0018) begin n_bad++; $display("FAIL tk_pre_addr: got %h want bfc00018", ic.inst_addr); end
        bpu_pred_valid = 1'b1; bpu_br_taken = 1'b1; ds_pc = 32'hbfc0_0010; bpu_target = 32'hbfc0_0100;
        settle();
        n_cmp++; if (fs_cancel !== 1'b1) begin n_bad++; $display("FAIL tk_cancel: got %b want 1", fs_cancel); end
        adv();
        bpu_pred_valid = 1'b0; bpu_br_taken = 1'b0;
        settle();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0100) begin n_bad++; $display("FAIL tk_addr: got %h want bfc00100", ic.inst_addr); end
        n_cmp++; if (fs_cancel !== 1'b0) begin n_bad++; $display("FAIL tk_cancel_once: got %b want 0", fs_cancel); end
    endtask

    task automatic test_wait_ds();
        do_reset();
        repeat (5) adv();
        ic.inst_addr_ok = 1'b0;
        bpu_pred_valid = 1'b1; bpu_br_taken = 1'b1; ds_pc = 32'hbfc0_0010; bpu_target = 32'hbfc0_0100;
        settle();
        n_cmp++; if (fs_cancel !== 1'b0) begin n_bad++; $display("FAIL wd_cancel: got %b want 0", fs_cancel); end
        adv();
        bpu_pred_valid = 1'b0; bpu_br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (ic.inst_addr !== 32'hbfc0_0014) begin n_bad++; $display("FAIL wd_hold%0d: got %h want bfc00014", i, ic.inst_addr); end
            adv();
        end
        ic.inst_addr_ok = 1'b1;
        settle();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0014) begin n_bad++; $display("FAIL wd_ds_addr: got %h want bfc00014", ic.inst_addr); end
        n_cmp++; if (fs_cancel !== 1'b0) begin n_bad++; $display("FAIL wd_ds_cancel: got %b want 0", fs_cancel); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0100) begin n_bad++; $display("FAIL wd_target: got %h want bfc00100", ic.inst_addr); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0104) begin n_bad++; $display("FAIL wd_after: got %h want bfc00104", ic.inst_addr); end
    endtask

    task automatic test_correction();
        do_reset();
        repeat (2) adv();
        bpu_is_correction = 1'b1; bpu_correct_target = 32'hbfc0_0200;
        settle();
        n_cmp++; if (fs_cancel !== 1'b1) begin n_bad++; $display("FAIL co_cancel: got %b want 1", fs_cancel); end
        adv();
        fs_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (ic.inst_addr !== 32'hbfc0_0200) begin n_bad++; $display("FAIL co_hold%0d: got %h want bfc00200", i, ic.inst_addr); end
            n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL co_early%0d: got %b want 0", i, correct_finish); end
            adv();
        end
        fs_stall = 1'b0;
        settle();
        n_cmp++; if (correct_finish !== 1'b1) begin n_bad++; $display("FAIL co_finish: got %b want 1", correct_finish); end
        adv();
        bpu_is_correction = 1'b0;
        settle();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0204) begin n_bad++; $display("FAIL co_next: got %h want bfc00204", ic.inst_addr); end
        n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL co_once: got %b want 0", correct_finish); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        repeat (5) adv();
        flush_valid = 1'b1; flush_target = 32'hbfc0_0380;
        bpu_is_correction = 1'b1; bpu_correct_target = 32'hbfc0_0200;
        bpu_pred_valid = 1'b1; bpu_br_taken = 1'b1; ds_pc = 32'hbfc0_0010; bpu_target = 32'hbfc0_0100;
        settle();
        n_cmp++; if (fs_cancel !== 1'b1) begin n_bad++; $display("FAIL fl_cancel: got %b want 1", fs_cancel); end
        n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL fl_finish: got %b want 0", correct_finish); end
        adv();
        idle_inputs();
        settle();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0380) begin n_bad++; $display("FAIL fl_addr: got %h want bfc00380", ic.inst_addr); end
        n_cmp++; if (correct_finish !== 1'b0) begin n_bad++; $display("FAIL fl_no_finish: got %b want 0", correct_finish); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0384) begin n_bad++; $display("FAIL fl_seq: got %h want bfc00384", ic.inst_addr); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        repeat (5) adv();
        ic.inst_addr_ok = 1'b0;
        bpu_pred_valid = 1'b1; bpu_br_taken = 1'b1; ds_pc = 32'hbfc0_0010; bpu_target = 32'hbfc0_0100;
        adv();
        bpu_pred_valid = 1'b0; bpu_br_taken = 1'b0;
        reset = 1'b1;
        settle();
        n_cmp++; if (ic.inst_req !== 1'b0) begin n_bad++; $display("FAIL rw_req: got %b want 0", ic.inst_req); end
        adv();
        reset = 1'b0; ic.inst_addr_ok = 1'b1;
        settle();
        n_cmp++; if (ic.inst_addr !== RST_PC) begin n_bad++; $display("FAIL rw_addr: got %h want %h", ic.inst_addr, RST_PC); end
        adv();
        n_cmp++; if (ic.inst_addr !== 32'hbfc0_0004) begin n_bad++; $display("FAIL rw_dropped: got %h want bfc00004", ic.inst_addr); end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset              = ($urandom_range(0, 299) == 0);
            flush_valid        = ($urandom_range(0, 15) == 0);
            flush_target       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            bpu_is_correction  = ($urandom_range(0, 9) == 0);
            bpu_correct_target = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            bpu_pred_valid     = ($urandom_range(0, 2) == 0);
            bpu_br_taken       = $urandom_range(0, 1) == 1;
            bpu_target         = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            case ($urandom_range(0, 3))
                0: ds_pc = m_pc - 32'd4;
                1: ds_pc = m_pc - 32'd8;
                2: ds_pc = m_newest - 32'd4;
                default: ds_pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            endcase
            fs_stall           = ($urandom_range(0, 4) == 0);
            ic.inst_addr_ok    = ($urandom_range(0, 3) != 0);
            settle();
            model_eval();
            n_cmp++; if (ic.inst_req !== e_req) begin n_bad++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, ic.inst_req, e_req); end
            n_cmp++; if (ic.inst_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, ic.inst_addr, e_addr); end
            n_cmp++; if (fs_cancel !== e_cancel) begin n_bad++; $display("FAIL rnd_cancel@%0d: got %b want %b", cyc, fs_cancel, e_cancel); end
            n_cmp++; if (correct_finish !== e_finish) begin n_bad++; $display("FAIL rnd_finish@%0d: got %b want %b", cyc, correct_finish, e_finish); end
            adv();
            model_commit();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_taken_after_ds();
        test_wait_ds();
        test_correction();
        test_flush_priority();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
